// File: rtl/spi_frame_engine.sv
// SPI mode-0 slave frame engine: snapshots positions at frame start, stages settings, commits atomically.
// Optional MOSI/MISO checksum byte enabled by defining SPI_CHECKSUM_EN.
module spi_frame_engine #(
   parameter int NCH    = 4,
   parameter int PW     = 21,
   parameter int VW     = 12,
   parameter int T      = 5,
   parameter int DOUT_W = 16,
   parameter int DIN_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sck,
   input  logic                ssel,
   input  logic                mosi,
   output logic                miso,
   input  logic [NCH*PW-1:0]   pos,
   input  logic [DIN_W-1:0]    din,
   input  logic [15:0]         rpm,
   output logic [NCH*VW-1:0]   vel,
   output logic [DOUT_W-1:0]   dout,
   output logic [T-1:0]        dirtime,
   output logic [T-1:0]        steptime,
   output logic [1:0]          tap,
   output logic                spol,
   output logic [NCH-1:0]      dpol,
   output logic [7:0]          pwm,
   output logic                commit_stb,
   output logic                frame_active,
   output logic                err_len,
   output logic                err_sum
);

   localparam int NB = 4*NCH + 8;
   localparam int B  = 4*NCH;
   localparam logic [5:0] NB_C = 6'(NB);
   localparam logic [5:0] B_C  = 6'(B);

   logic [2:0]        sck_q, ssel_q;
   logic              sck_rise, sck_fall, ssel_rise, ssel_fall;
   logic              frame_active_q, active_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [5:0]        byte_cnt_q, byte_cnt_d, byte_cnt_inc;
   logic [7:0]        rx_q, rx_d, rx_byte;
   logic [7:0]        tx_q, tx_d, tx_byte;
   logic [NCH*PW-1:0] snap_q, snap_d, pos_src;
   logic [5:0]        tx_idx, tx_off;
   logic              tx_load;
   logic              wr_en, end_act, len_ok, sum_ok, commit;
   logic [7:0]        ck_byte;
   logic [7:0]        stage_q [NB];
   logic              err_len_q, err_sum_q, commit_stb_q;
   logic [7:0]        seq_q;
   logic [NCH*VW-1:0] vel_q, vel_d;
   logic [NCH-1:0]    dpol_q;
   logic [DOUT_W-1:0] dout_q;
   logic [T-1:0]      dirtime_q, steptime_q;
   logic [1:0]        tap_q;
   logic              spol_q;
   logic [7:0]        pwm_q;
   logic [23:0]       pos_k;

   // Edges are taken from the two oldest stages so both inputs see identical latency.
   assign sck_rise  =  sck_q[1]  & ~sck_q[2];
   assign sck_fall  = ~sck_q[1]  &  sck_q[2];
   assign ssel_rise =  ssel_q[1] & ~ssel_q[2];
   assign ssel_fall = ~ssel_q[1] &  ssel_q[2];

   assign rx_byte      = {rx_q[6:0], mosi};
   assign byte_cnt_inc = (byte_cnt_q == 6'd63) ? 6'd63 : byte_cnt_q + 6'd1;
   assign wr_en        = frame_active_q & ~ssel_fall & sck_rise & (bit_cnt_q == 4'd7);
   assign end_act      = frame_active_q & ssel_rise;
   assign len_ok       = (byte_cnt_q == NB_C) && (bit_cnt_q == 4'd0);
   assign commit       = end_act & len_ok & sum_ok;
   assign pos_src      = ssel_fall ? pos : snap_q;

   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      snap_d     = snap_q;
      active_d   = frame_active_q;
      tx_idx     = byte_cnt_inc;
      tx_load    = 1'b0;
      if (ssel_fall) begin
         bit_cnt_d  = 4'd0;
         byte_cnt_d = 6'd0;
         active_d   = 1'b1;
         snap_d     = pos;
         tx_idx     = 6'd0;
         tx_load    = 1'b1;
      end else if (frame_active_q) begin
         if (sck_rise && bit_cnt_q != 4'd8) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
         if (sck_fall) begin
            if (bit_cnt_q == 4'd8) begin
               bit_cnt_d  = 4'd0;
               byte_cnt_d = byte_cnt_inc;
               tx_load    = 1'b1;
            end else begin
               tx_d = {tx_q[6:0], 1'b0};
            end
         end
         if (ssel_rise) active_d = 1'b0;
      end
      if (tx_load) tx_d = tx_byte;
   end

   always_comb begin
      tx_byte = 8'h00;
      pos_k   = 24'h0;
      tx_off  = tx_idx - B_C;
      if (tx_idx < B_C) begin
         for (int k = 0; k < NCH; k++) begin
            if (tx_idx[5:2] == 4'(k)) pos_k = 24'(pos_src[k*PW +: PW]);
         end
         case (tx_idx[1:0])
            2'd0:    tx_byte = pos_k[7:0];
            2'd1:    tx_byte = pos_k[15:8];
            2'd2:    tx_byte = pos_k[23:16];
            default: tx_byte = 8'h00;
         endcase
      end else if (tx_idx < NB_C) begin
         case (tx_off)
            6'd0:    tx_byte = din[7:0];
            6'd1:    tx_byte = 8'(din >> 8);
            6'd2:    tx_byte = rpm[7:0];
            6'd3:    tx_byte = rpm[15:8];
            6'd4:    tx_byte = {err_len_q, err_sum_q, 6'b0};
            6'd5:    tx_byte = seq_q;
            6'd7:    tx_byte = ck_byte;
            default: tx_byte = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_q          <= '0;
         ssel_q         <= '0;
         frame_active_q <= 1'b0;
         bit_cnt_q      <= '0;
         byte_cnt_q     <= '0;
         rx_q           <= '0;
         tx_q           <= '0;
         snap_q         <= '0;
      end else begin
         sck_q          <= {sck_q[1:0], sck};
         ssel_q         <= {ssel_q[1:0], ssel};
         frame_active_q <= active_d;
         bit_cnt_q      <= bit_cnt_d;
         byte_cnt_q     <= byte_cnt_d;
         rx_q           <= rx_d;
         tx_q           <= tx_d;
         snap_q         <= snap_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_stage
         always_ff @(posedge clk) begin
            if (rst)
               stage_q[gi] <= 8'h00;
            else if (wr_en && byte_cnt_q == 6'(gi))
               stage_q[gi] <= rx_byte;
         end
      end
      for (gi = 0; gi < NCH; gi++) begin : g_vel
         assign vel_d[gi*VW +: VW] = {stage_q[4*gi+1][VW-9:0], stage_q[4*gi]};
      end
   endgenerate

`ifdef SPI_CHECKSUM_EN
   logic [7:0] rx_sum_q, tx_sum_q;

   // The MISO sum follows the bytes actually loaded, so live din/rpm stay consistent with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sum_q <= 8'h00;
         tx_sum_q <= 8'h00;
         err_sum_q <= 1'b0;
      end else begin
         if (ssel_fall)
            rx_sum_q <= 8'h00;
         else if (wr_en && byte_cnt_q < NB_C - 6'd1)
            rx_sum_q <= rx_sum_q + rx_byte;
         if (tx_load && tx_idx < NB_C - 6'd1)
            tx_sum_q <= (ssel_fall ? 8'h00 : tx_sum_q) + tx_byte;
         if (end_act)
            err_sum_q <= (byte_cnt_q >= NB_C) && !sum_ok;
      end
   end
   assign sum_ok  = (rx_sum_q == stage_q[NB-1]);
   assign ck_byte = tx_sum_q;
`else
   assign err_sum_q = 1'b0;
   assign sum_ok    = 1'b1;
   assign ck_byte   = 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         vel_q        <= '0;
         dout_q       <= '0;
         dirtime_q    <= '0;
         steptime_q   <= '0;
         tap_q        <= '0;
         spol_q       <= 1'b0;
         dpol_q       <= '0;
         pwm_q        <= '0;
         seq_q        <= '0;
         err_len_q    <= 1'b0;
         commit_stb_q <= 1'b0;
      end else begin
         commit_stb_q <= commit;
         if (end_act) err_len_q <= ~len_ok;
         if (commit) begin
            vel_q      <= vel_d;
            dout_q     <= {stage_q[B+1][DOUT_W-9:0], stage_q[B]};
            spol_q     <= stage_q[B+2][7];
            dirtime_q  <= stage_q[B+2][T-1:0];
            tap_q      <= stage_q[B+3][7:6];
            steptime_q <= stage_q[B+3][T-1:0];
            pwm_q      <= stage_q[B+4];
            dpol_q     <= stage_q[B+5][NCH-1:0];
            seq_q      <= seq_q + 8'd1;
         end
      end
   end

   assign miso         = tx_q[7];
   assign vel          = vel_q;
   assign dout         = dout_q;
   assign dirtime      = dirtime_q;
   assign steptime     = steptime_q;
   assign tap          = tap_q;
   assign spol         = spol_q;
   assign dpol         = dpol_q;
   assign pwm          = pwm_q;
   assign commit_stb   = commit_stb_q;
   assign frame_active = frame_active_q;
   assign err_len      = err_len_q;
   assign err_sum      = err_sum_q;

endmodule

// File: tb/tb_spi_frame_engine.sv
// Directed bench for spi_frame_engine (NCH=4, 24-byte frames); works with or without SPI_CHECKSUM_EN.
module tb_spi_frame_engine;
   localparam int NCH = 4, PW = 21, VW = 12, T = 5, DOUT_W = 16, DIN_W = 16;
   localparam int HALF = 60;

   logic clk = 1'b0, rst = 1'b1, sck = 1'b0, ssel = 1'b1, mosi = 1'b0;
   logic miso;
   logic [NCH*PW-1:0] pos;
   logic [DIN_W-1:0]  din;
   logic [15:0]       rpm;
   logic [NCH*VW-1:0] vel;
   logic [DOUT_W-1:0] dout;
   logic [T-1:0]      dirtime, steptime;
   logic [1:0]        tap;
   logic              spol;
   logic [NCH-1:0]    dpol;
   logic [7:0]        pwm;
   logic              commit_stb, frame_active, err_len, err_sum;

   spi_frame_engine #(.NCH(NCH), .PW(PW), .VW(VW), .T(T), .DOUT_W(DOUT_W), .DIN_W(DIN_W)) dut (
      .clk(clk), .rst(rst), .sck(sck), .ssel(ssel), .mosi(mosi), .miso(miso),
      .pos(pos), .din(din), .rpm(rpm), .vel(vel), .dout(dout),
      .dirtime(dirtime), .steptime(steptime), .tap(tap), .spol(spol), .dpol(dpol),
      .pwm(pwm), .commit_stb(commit_stb), .frame_active(frame_active),
      .err_len(err_len), .err_sum(err_sum)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, stb_cnt = 0;
   int pos_chg_at = -1, rst_at = -1;
   logic fa_start;
   logic [7:0] mo [64];
   logic [7:0] mi [64];

   always @(negedge clk) if (commit_stb) stb_cnt++;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
      for (int i = 7; i >= 0; i--) begin
         mosi = b[i];
         #HALF sck = 1'b1;
         r[i] = miso;
         #HALF sck = 1'b0;
      end
   endtask

   task automatic run_frame(input int n);
      logic [7:0] r;
      stb_cnt = 0;
      ssel = 1'b0;
      #100 fa_start = frame_active;
      for (int i = 0; i < n; i++) begin
         if (i == pos_chg_at) pos[PW-1:0] = 21'h00001;
         if (i == rst_at) begin
            rst = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
         end
         spi_byte(mo[i], r);
         mi[i] = r;
      end
      #100 ssel = 1'b1;
      #200;
   endtask

   // Payload: vel0 lo/hi, vel1 = 0xFFF, dout 0x5AA5, spol=1 dirtime=0x0A, tap=2 steptime=7, dpol=5.
   task automatic fill(input logic [7:0] v0lo, input logic [7:0] pwmb, input logic [7:0] ck_err);
      logic [7:0] s;
      for (int i = 0; i < 64; i++) mo[i] = 8'h00;
      mo[0] = v0lo;  mo[1] = 8'h12; mo[4] = 8'hFF; mo[5] = 8'hFF;
      mo[16] = 8'hA5; mo[17] = 8'h5A; mo[18] = 8'h8A; mo[19] = 8'h87;
      mo[20] = pwmb;  mo[21] = 8'h05;
      s = 8'h00;
      for (int i = 0; i < 23; i++) s = s + mo[i];
      mo[23] = s + ck_err;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] exp_ck;
`ifdef SPI_CHECKSUM_EN
      exp_ck = 8'h10;
`else
      exp_ck = 8'h00;
`endif
      pos = '0;
      pos[PW-1:0]      = 21'h12345;
      pos[PW +: PW]    = 21'h1ABCDE;
      din = 16'hBEEF;
      rpm = 16'h1234;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_val("rst_vel", vel, 0);
      check_val("rst_dout", dout, 0);
      check_val("rst_pwm", pwm, 0);
      check_val("rst_dirtime", dirtime, 0);
      check_val("rst_tap", tap, 0);
      check_val("rst_spol", spol, 0);
      check_val("rst_dpol", dpol, 0);
      check_val("rst_miso", miso, 0);
      check_val("rst_active", frame_active, 0);
      check_val("rst_err_len", err_len, 0);
      check_val("rst_err_sum", err_sum, 0);

      // Good frame; pos0 changes after byte 0 has gone out.
      fill(8'h34, 8'h80, 8'h00);
      pos_chg_at = 1;
      run_frame(24);
      pos_chg_at = -1;
      check_val("f1_active_start", fa_start, 1);
      check_val("f1_miso0", mi[0], 8'h45);
      check_val("f1_miso1", mi[1], 8'h23);
      check_val("f1_miso2", mi[2], 8'h01);
      check_val("f1_miso3", mi[3], 8'h00);
      check_val("f1_miso4", mi[4], 8'hDE);
      check_val("f1_miso5", mi[5], 8'hBC);
      check_val("f1_miso6", mi[6], 8'h1A);
      check_val("f1_din_lo", mi[16], 8'hEF);
      check_val("f1_din_hi", mi[17], 8'hBE);
      check_val("f1_rpm_lo", mi[18], 8'h34);
      check_val("f1_rpm_hi", mi[19], 8'h12);
      check_val("f1_status", mi[20], 8'h00);
      check_val("f1_seq", mi[21], 8'h00);
      check_val("f1_cksum", mi[23], exp_ck);
      check_val("f1_vel", vel, 48'h000000FFF234);
      check_val("f1_dout", dout, 16'h5AA5);
      check_val("f1_spol", spol, 1);
      check_val("f1_dirtime", dirtime, 5'h0A);
      check_val("f1_tap", tap, 2);
      check_val("f1_steptime", steptime, 5'h07);
      check_val("f1_dpol", dpol, 4'h5);
      check_val("f1_pwm", pwm, 8'h80);
      check_val("f1_stb", stb_cnt, 1);
      check_val("f1_err_len", err_len, 0);
      check_val("f1_active_end", frame_active, 0);

      // Aborted after 10 bytes.
      fill(8'h77, 8'h11, 8'h00);
      run_frame(10);
      check_val("ab_vel", vel, 48'h000000FFF234);
      check_val("ab_dout", dout, 16'h5AA5);
      check_val("ab_pwm", pwm, 8'h80);
      check_val("ab_stb", stb_cnt, 0);
      check_val("ab_err_len", err_len, 1);
      check_val("ab_err_sum", err_sum, 0);

      // 25-byte frame.
      fill(8'h77, 8'h11, 8'h00);
      mo[24] = 8'h33;
      run_frame(25);
      check_val("ov_miso0", mi[0], 8'h01);
      check_val("ov_status", mi[20], 8'h80);
      check_val("ov_seq", mi[21], 8'h01);
      check_val("ov_byte24", mi[24], 8'h00);
      check_val("ov_stb", stb_cnt, 0);
      check_val("ov_pwm", pwm, 8'h80);
      check_val("ov_err_len", err_len, 1);
      check_val("ov_err_sum", err_sum, 0);

      // Checksum off by one, then a correct frame.
      fill(8'h56, 8'h40, 8'h01);
      run_frame(24);
`ifdef SPI_CHECKSUM_EN
      check_val("bc_stb", stb_cnt, 0);
      check_val("bc_pwm", pwm, 8'h80);
      check_val("bc_err_sum", err_sum, 1);
      check_val("bc_err_len", err_len, 0);
`else
      check_val("bc_stb", stb_cnt, 1);
      check_val("bc_pwm", pwm, 8'h40);
      check_val("bc_err_sum", err_sum, 0);
      check_val("bc_err_len", err_len, 0);
`endif
      fill(8'h56, 8'h40, 8'h00);
      run_frame(24);
      check_val("gc_stb", stb_cnt, 1);
      check_val("gc_pwm", pwm, 8'h40);
      check_val("gc_vel", vel, 48'h000000FFF256);
      check_val("gc_err_sum", err_sum, 0);
      check_val("gc_err_len", err_len, 0);
`ifdef SPI_CHECKSUM_EN
      check_val("gc_seq", mi[21], 8'h01);
`else
      check_val("gc_seq", mi[21], 8'h02);
`endif

      // Reset asserted before byte 5 of an otherwise good frame.
      fill(8'h34, 8'h80, 8'h00);
      rst_at = 5;
      run_frame(24);
      rst_at = -1;
      check_val("rs_stb", stb_cnt, 0);
      check_val("rs_vel", vel, 0);
      check_val("rs_dout", dout, 0);
      check_val("rs_pwm", pwm, 0);
      check_val("rs_active", frame_active, 0);
      check_val("rs_miso", miso, 0);

      // Fresh frame after reset.
      run_frame(24);
      check_val("nf_status", mi[20], 8'h00);
      check_val("nf_seq", mi[21], 8'h00);
      check_val("nf_stb", stb_cnt, 1);
      check_val("nf_pwm", pwm, 8'h80);
      check_val("nf_vel", vel, 48'h000000FFF234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_frame_engine.md
Name: spi_frame_engine

Overview:
Parametrised SPI slave frame engine for the stepper CPLD; successor to the fixed 4-axis SPI register block. Supports NCH step channels and a fixed per-channel byte layout. Latches a coherent position snapshot at frame start. Stages all received settings and commits them atomically only on a well-formed frame, with optional checksum and error/sequence reporting. Sits between the Raspberry Pi SPI pins and the stepgen/pwm/wdt instances.

Parameters:
NCH, 4, step channels (1..8)
PW, 21, position width per channel (<=24)
VW, 12, velocity width per channel (9..16)
T, 5, dirtime/steptime width (<=6)
DOUT_W, 16, digital output width (9..16)
DIN_W, 16, digital input width (9..16)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
sck  in  1  SPI clock, async, mode 0
ssel  in  1  SPI select, async, active low
mosi  in  1  SPI data in
miso  out  1  SPI data out, MSB first
pos  in  NCH*PW  channel positions, ch k at [k*PW +: PW]
din  in  DIN_W  digital inputs
rpm  in  16  spindle rpm count
vel  out  NCH*VW  committed velocities, ch k at [k*VW +: VW]
dout  out  DOUT_W  committed digital outputs
dirtime  out  T  committed dir setup time
steptime  out  T  committed step length
tap  out  2  committed stepgen tap
spol  out  1  step polarity
dpol  out  NCH  dir polarity
pwm  out  8  PWM duty
commit_stb  out  1  one-cycle pulse on commit
frame_active  out  1  high while a frame is in progress
err_len  out  1  last frame had wrong byte count
err_sum  out  1  last frame failed checksum (0 if feature off)

Behaviour:
- Sync: sck and ssel each pass through a 3-flop chain; edges detected on stages [2:1]. mosi is sampled unsynchronised at the detected sck rise.
- Frame length is NB = 4*NCH+8 bytes. Byte counter is 6 bits and saturates at 63.
- Frame start (ssel fall detected):
  - bit and byte counters clear; frame_active <= 1.
  - All pos are copied into a snapshot register.
  - The TX shift register loads byte 0 in the same cycle.
- RX: each sck rise shifts mosi in. On the 8th rise the byte is written to staging at index byte_cnt.
- TX: miso = tx[7]. Each sck fall shifts left. On the fall after the 8th rise, byte_cnt increments and the next TX byte loads instead of shifting.
- MOSI map, channel k:
  - 4k = vel lo; 4k+1 = vel hi, bits [VW-9:0] used; 4k+2..4k+3 ignored.
- MOSI map, B = 4*NCH:
  - B = dout[7:0]; B+1 = dout[DOUT_W-1:8]
  - B+2 = {spol, -, dirtime}; B+3 = {tap[1:0], steptime}
  - B+4 = pwm; B+5 = dpol[NCH-1:0]; B+6 reserved
  - B+7 = checksum
- MISO map:
  - 4k..4k+2 = snapshot pos_k bytes, zero-extended; 4k+3 = 0x00
  - B,B+1 = din; B+2,B+3 = rpm
  - B+4 = status {err_len, err_sum, 6'b0} from the previous frame; B+5 = frame sequence counter
  - B+6 = 0x00; B+7 = checksum of MISO bytes 0..B+6 (0x00 if feature off)
  - Bytes >= NB transmit 0x00.
- Frame end (ssel rise detected): frame_active <= 0.
  - Commit if byte_cnt == NB exactly, all bits complete, and checksum passes.
  - On commit: all staged fields copy to outputs in one cycle; commit_stb high for exactly 1 clk the next cycle; seq increments mod 256; err_len and err_sum clear.
  - Otherwise: outputs unchanged and no strobe. err_len set if count != NB or a partial byte is pending; err_sum set on checksum mismatch.
- Bytes received past NB are ignored and force err_len.
- sck edges while ssel is inactive are ignored.
- Reset values: all outputs, staging, snapshot, seq, error flags, counters and the tx register are 0; miso = 0; frame_active = 0.
- Reset mid-frame aborts the frame with no commit. Frames are accepted again only after a fresh ssel fall.
- A commit and a new ssel fall in the same clk cannot occur: a 1-clk gap is guaranteed by the 3-flop sync.

Optional Feature:
SPI_CHECKSUM_EN.
- Defined: MOSI byte NB-1 must equal the sum mod 256 of MOSI bytes 0..NB-2, else no commit and err_sum = 1. MISO byte NB-1 is the sum mod 256 of MISO bytes 0..NB-2.
- Undefined: byte NB-1 is ignored on MOSI and sent as 0x00 on MISO; err_sum is tied 0; commit depends only on length.

Test Plan:
- Reset then full 24-byte frame (NCH=4): vel0 bytes 0x34,0x12; dout bytes 0xA5,0x5A; pwm 0x80; correct sum -> vel0=0x234, dout=0x5AA5, pwm=0x80, commit_stb one 1-clk pulse, seq=1.
- pos0=0x12345 at ssel fall, changed to 0x00001 mid-frame -> MISO bytes 0..2 = 0x45,0x23,0x01.
- Frame aborted after 10 bytes -> outputs unchanged, no strobe; next frame's MISO byte B+4 = 0x80.
- 25-byte frame -> no commit, err_len=1; byte 24 on MISO = 0x00.
- With SPI_CHECKSUM_EN, checksum byte off by 1 -> no commit, err_sum=1. A following good frame commits and clears both error flags.
- rst asserted at byte 5 of a frame, then released; ssel rises -> no commit, all outputs 0, seq=0.
